// File: rtl/aim_track_ctrl.sv
// Per-frame pan/tilt tracker: SEARCH/TRACK/LOCK/FIRE FSM with a registered laser pulse.
// Latency 1 cycle from frame_done; a new command is dropped while cmd_valid waits on cmd_ready.
module aim_track_ctrl #(
  parameter int CENTER_X    = 160,
  parameter int CENTER_Y    = 120,
  parameter int DEADBAND    = 8,
  parameter int STEP_SHIFT  = 2,
  parameter int STEP_MAX    = 63,
  parameter int LOCK_FRAMES = 4,
  parameter int LOST_FRAMES = 8,
  parameter int FIRE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_done,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  input  logic       aim_detected,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       pan_dir,
  output logic [7:0] pan_steps,
  output logic       tilt_dir,
  output logic [7:0] tilt_steps,
  output logic       laser_on,
  output logic       locked,
  output logic [1:0] state
);

  localparam int CCW = $clog2(LOCK_FRAMES + 1);
  localparam int MCW = $clog2(LOST_FRAMES + 1);
  localparam int FCW = $clog2(FIRE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCK   = 2'd2,
    ST_FIRE   = 2'd3
  } state_e;

  typedef struct packed {
    logic       pan_dir;
    logic [7:0] pan_steps;
    logic       tilt_dir;
    logic [7:0] tilt_steps;
  } cmd_t;

  // Returns {centred, dir, steps} for one axis.
  function automatic logic [9:0] axis_eval(input logic [9:0] pos, input int center);
    logic signed [10:0] e;
    logic [10:0]        mag;
    logic [10:0]        shifted;
    logic [7:0]         steps;
    logic               centred;
    logic               dir;
    e       = $signed({1'b0, pos}) - $signed(11'(center));
    mag     = e[10] ? $unsigned(-e) : $unsigned(e);
    centred = (mag <= 11'(DEADBAND));
    shifted = mag >> STEP_SHIFT;
    if (centred)
      steps = 8'd0;
    else if (shifted > 11'(STEP_MAX))
      steps = 8'(STEP_MAX);
    else
      steps = shifted[7:0];
    dir = !e[10] && (e != '0) && (steps != 8'd0);
    return {centred, dir, steps};
  endfunction

  state_e         state_q, state_d;
  logic [CCW-1:0] center_cnt_q, center_cnt_d;
  logic [MCW-1:0] miss_cnt_q, miss_cnt_d;
  logic [FCW-1:0] fire_cnt_q, fire_cnt_d;
  logic           cmd_valid_q, cmd_valid_d;
  cmd_t           cmd_q, cmd_d;
  logic           laser_q, locked_q;

  logic [9:0] pan_eval, tilt_eval;
  cmd_t       cmd_new;
  logic       frame_centred, issue;
  logic [CCW-1:0] center_inc;
  logic [MCW-1:0] miss_inc;

  assign pan_eval      = axis_eval(aim_x, CENTER_X);
  assign tilt_eval     = axis_eval(aim_y, CENTER_Y);
  assign cmd_new       = '{pan_dir: pan_eval[8], pan_steps: pan_eval[7:0],
                           tilt_dir: tilt_eval[8], tilt_steps: tilt_eval[7:0]};
  assign frame_centred = aim_detected && pan_eval[9] && tilt_eval[9];
  assign center_inc    = (center_cnt_q == CCW'(LOCK_FRAMES)) ? center_cnt_q : center_cnt_q + 1'b1;
  assign miss_inc      = (miss_cnt_q == MCW'(LOST_FRAMES)) ? miss_cnt_q : miss_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    center_cnt_d = center_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    fire_cnt_d   = fire_cnt_q;
    issue        = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (frame_done && aim_detected) begin
          state_d      = ST_TRACK;
          center_cnt_d = '0;
          miss_cnt_d   = '0;
        end
      end
      ST_TRACK: begin
        if (frame_done) begin
          if (!aim_detected) begin
            center_cnt_d = '0;
            miss_cnt_d   = miss_inc;
            if (miss_inc == MCW'(LOST_FRAMES)) state_d = ST_SEARCH;
          end else if (frame_centred) begin
            miss_cnt_d   = '0;
            center_cnt_d = center_inc;
            if (center_inc == CCW'(LOCK_FRAMES)) state_d = ST_LOCK;
          end else begin
            center_cnt_d = '0;
            miss_cnt_d   = '0;
            issue        = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        if (frame_done) begin
          center_cnt_d = '0;
          miss_cnt_d   = '0;
          if (frame_centred) begin
            state_d    = ST_FIRE;
            fire_cnt_d = FCW'(FIRE_CYCLES - 1);
          end else if (aim_detected) begin
            state_d = ST_TRACK;
            issue   = 1'b1;
          end else begin
            state_d    = ST_TRACK;
            miss_cnt_d = MCW'(1);
          end
        end
      end
      ST_FIRE: begin
        // fire_cnt counts down the remaining pulse cycles; frame_done is ignored here.
        if (fire_cnt_q == '0) begin
          state_d      = ST_TRACK;
          center_cnt_d = '0;
          miss_cnt_d   = '0;
        end else begin
          fire_cnt_d = fire_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    // A completing transfer blocks any same-cycle issue, since cmd_valid_q is still high.
    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end else if (issue && !cmd_valid_q &&
                 (cmd_new.pan_steps != 8'd0 || cmd_new.tilt_steps != 8'd0)) begin
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SEARCH;
      center_cnt_q <= '0;
      miss_cnt_q   <= '0;
      fire_cnt_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= '0;
      laser_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      center_cnt_q <= center_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      fire_cnt_q   <= fire_cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      laser_q      <= (state_d == ST_FIRE);
      locked_q     <= (state_d == ST_LOCK);
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign pan_dir    = cmd_q.pan_dir;
  assign pan_steps  = cmd_q.pan_steps;
  assign tilt_dir   = cmd_q.tilt_dir;
  assign tilt_steps = cmd_q.tilt_steps;
  assign laser_on   = laser_q;
  assign locked     = locked_q;
  assign state      = state_q;

endmodule

// File: tb/tb_aim_track_ctrl.sv
// Bench for aim_track_ctrl: directed scenarios then randomized frames against a frame-level model.
module tb_aim_track_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_done = 1'b0;
  logic [9:0] aim_x = 10'd0;
  logic [9:0] aim_y = 10'd0;
  logic       aim_detected = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       pan_dir;
  logic [7:0] pan_steps;
  logic       tilt_dir;
  logic [7:0] tilt_steps;
  logic       laser_on;
  logic       locked;
  logic [1:0] state;

  aim_track_ctrl dut (
    .clk(clk), .reset(reset), .frame_done(frame_done),
    .aim_x(aim_x), .aim_y(aim_y), .aim_detected(aim_detected),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .pan_dir(pan_dir), .pan_steps(pan_steps),
    .tilt_dir(tilt_dir), .tilt_steps(tilt_steps),
    .laser_on(laser_on), .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0..3 = SEARCH/TRACK/LOCK/FIRE
  int m_mode, m_centred_run, m_missed_run, m_fire_left;
  int m_vld, m_pd, m_ps, m_td, m_ts;

  task automatic m_reset();
    m_mode = 0; m_centred_run = 0; m_missed_run = 0; m_fire_left = 0;
    m_vld = 0; m_pd = 0; m_ps = 0; m_td = 0; m_ts = 0;
  endtask

  task automatic axis(input int p, input int c, output int dir, output int st, output bit cen);
    int e, a;
    e = p - c;
    a = (e < 0) ? -e : e;
    cen = (a <= 8);
    st = cen ? 0 : ((a / 4 > 63) ? 63 : a / 4);
    dir = (e > 0 && st > 0) ? 1 : 0;
  endtask

  task automatic m_update();
    int pd, ps, td, ts;
    bit cx, cy, fc, want, xfer;
    axis(int'(aim_x), 160, pd, ps, cx);
    axis(int'(aim_y), 120, td, ts, cy);
    fc = aim_detected && cx && cy;
    want = 0;
    xfer = (m_vld == 1) && cmd_ready;
    case (m_mode)
      0: if (frame_done && aim_detected) begin
           m_mode = 1; m_centred_run = 0; m_missed_run = 0;
         end
      1: if (frame_done) begin
           if (!aim_detected) begin
             m_centred_run = 0;
             m_missed_run = (m_missed_run < 8) ? m_missed_run + 1 : 8;
             if (m_missed_run == 8) m_mode = 0;
           end else if (fc) begin
             m_missed_run = 0;
             m_centred_run = (m_centred_run < 4) ? m_centred_run + 1 : 4;
             if (m_centred_run == 4) m_mode = 2;
           end else begin
             m_centred_run = 0; m_missed_run = 0; want = 1;
           end
         end
      2: if (frame_done) begin
           m_centred_run = 0; m_missed_run = 0;
           if (fc) begin
             m_mode = 3; m_fire_left = 16;
           end else if (aim_detected) begin
             m_mode = 1; want = 1;
           end else begin
             m_mode = 1; m_missed_run = 1;
           end
         end
      default: begin
        m_fire_left--;
        if (m_fire_left == 0) begin
          m_mode = 1; m_centred_run = 0; m_missed_run = 0;
        end
      end
    endcase
    if (xfer) m_vld = 0;
    else if (want && m_vld == 0 && (ps > 0 || ts > 0)) begin
      m_vld = 1; m_pd = pd; m_ps = ps; m_td = td; m_ts = ts;
    end
  endtask

  task automatic compare_all();
    check_eq("state", int'(state), m_mode);
    check_eq("cmd_valid", int'(cmd_valid), m_vld);
    check_eq("pan_dir", int'(pan_dir), m_pd);
    check_eq("pan_steps", int'(pan_steps), m_ps);
    check_eq("tilt_dir", int'(tilt_dir), m_td);
    check_eq("tilt_steps", int'(tilt_steps), m_ts);
    check_eq("laser_on", int'(laser_on), (m_mode == 3) ? 1 : 0);
    check_eq("locked", int'(locked), (m_mode == 2) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) m_reset();
    else m_update();
    #1;
    compare_all();
  endtask

  task automatic frame(input int x, input int y, input bit det);
    aim_x = 10'(x); aim_y = 10'(y); aim_detected = det;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int laser_cycles;

  initial begin
    m_reset();
    #12;
    compare_all();
    check_eq("reset_state", int'(state), 0);
    reset = 1'b1;
    idle(2);

    frame(160, 120, 1);
    check_eq("enter_track", int'(state), 1);
    check_eq("enter_track_novld", int'(cmd_valid), 0);

    frame(200, 100, 1);
    check_eq("cmd1_vld", int'(cmd_valid), 1);
    check_eq("cmd1_pan_dir", int'(pan_dir), 1);
    check_eq("cmd1_pan_steps", int'(pan_steps), 10);
    check_eq("cmd1_tilt_dir", int'(tilt_dir), 0);
    check_eq("cmd1_tilt_steps", int'(tilt_steps), 5);
    idle(3);
    frame(100, 120, 1);
    check_eq("dropped_pan_steps", int'(pan_steps), 10);
    check_eq("dropped_pan_dir", int'(pan_dir), 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check_eq("xfer_vld_low", int'(cmd_valid), 0);

    frame(1023, 120, 1);
    check_eq("sat_pan_steps", int'(pan_steps), 63);
    check_eq("sat_tilt_steps", int'(tilt_steps), 0);
    check_eq("sat_tilt_dir", int'(tilt_dir), 0);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;

    for (int i = 0; i < 4; i++) frame(163, 115, 1);
    check_eq("lock_locked", int'(locked), 1);
    frame(160, 120, 1);
    laser_cycles = 0;
    for (int i = 0; i < 24; i++) begin
      if (laser_on) laser_cycles++;
      if (i % 3 == 0) frame(250, 20, 1);
      else step();
    end
    check_eq("laser_len", laser_cycles, 16);
    check_eq("after_fire_state", int'(state), 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;

    for (int i = 0; i < 7; i++) frame(160, 120, 0);
    frame(160, 120, 1);
    check_eq("seven_miss_track", int'(state), 1);
    for (int i = 0; i < 7; i++) frame(160, 120, 0);
    check_eq("miss_cleared_track", int'(state), 1);
    frame(160, 120, 0);
    check_eq("lost_search", int'(state), 0);

    frame(160, 120, 1);
    for (int i = 0; i < 4; i++) frame(160, 120, 1);
    frame(160, 120, 1);
    idle(4);
    check_eq("fire5_laser", int'(laser_on), 1);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check_eq("async_laser", int'(laser_on), 0);
    check_eq("async_state", int'(state), 0);
    check_eq("async_vld", int'(cmd_valid), 0);
    idle(2);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      frame_done = ($urandom_range(0, 2) == 0);
      aim_detected = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) begin
        aim_x = 10'($urandom_range(0, 1023));
        aim_y = 10'($urandom_range(0, 1023));
      end else begin
        aim_x = 10'(160 + $urandom_range(0, 24) - 12);
        aim_y = 10'(120 + $urandom_range(0, 24) - 12);
      end
      cmd_ready = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aim_track_ctrl.md
# aim_track_ctrl

Frame-rate tracking controller placed between `red_tracker` and the pan/tilt motor driver. Once per video frame it samples the red-target centroid, computes the pixel error from the camera centre, and runs a SEARCH/TRACK/LOCK/FIRE state machine. It issues pan/tilt step commands over a valid/ready handshake and times the laser pulse. All logic runs in the `sys_clk` domain, sharing the clock with the VGA and tracker datapath.

## Interface
Parameters:
- CENTER_X, 160, pan setpoint in the 320×240 frame.
- CENTER_Y, 120, tilt setpoint.
- DEADBAND, 8, per-axis error magnitude (pixels, inclusive) treated as centred.
- STEP_SHIFT, 2, steps = |error| >> STEP_SHIFT.
- STEP_MAX, 63, saturation limit for a step count.
- LOCK_FRAMES, 4, consecutive centred frames in TRACK needed to enter LOCK.
- LOST_FRAMES, 8, consecutive missed frames in TRACK that return to SEARCH.
- FIRE_CYCLES, 16, laser pulse length in clk cycles (top overrides for hardware).

Ports:
- clk  in  1  system clock (sys_clk domain); one clock; all state is clocked on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- frame_done  in  1  one-cycle pulse; aim_* inputs are valid in the same cycle.
- aim_x  in  10  target centroid x.
- aim_y  in  10  target centroid y.
- aim_detected  in  1  target present this frame.
- cmd_valid  out  1  step command pending.
- cmd_ready  in  1  motor driver accepts the command.
- pan_dir  out  1  1 = target right of centre (aim_x > CENTER_X).
- pan_steps  out  8  pan step count.
- tilt_dir  out  1  1 = target below centre (aim_y > CENTER_Y).
- tilt_steps  out  8  tilt step count.
- laser_on  out  1  laser enable.
- locked  out  1  high while in LOCK.
- state  out  2  SEARCH=0, TRACK=1, LOCK=2, FIRE=3.

## Operation
- Error: ex = aim_x − CENTER_X, ey = aim_y − CENTER_Y, signed 11-bit.
  - Axis centred when |e| ≤ DEADBAND.
  - Axis steps = 0 if centred, else min(|e| >> STEP_SHIFT, STEP_MAX).
  - Direction bit = 1 iff e > 0; forced to 0 when steps = 0.
- A frame is "centred" when aim_detected = 1 and both axes are centred.
- Events are evaluated only on a frame_done cycle; frame_done is ignored in FIRE.
- SEARCH:
  - detected → TRACK, clearing center_cnt and miss_cnt.
  - No commands are issued.
- TRACK:
  - Detected and not centred: center_cnt ← 0, miss_cnt ← 0, issue a command.
  - Centred: miss_cnt ← 0, center_cnt + 1. When the new value equals LOCK_FRAMES → LOCK.
  - Not detected: center_cnt ← 0, miss_cnt + 1. When the new value equals LOST_FRAMES → SEARCH.
- LOCK:
  - Next frame centred → FIRE and load fire_cnt.
  - Next frame detected but not centred → TRACK, center_cnt ← 0, issue a command.
  - Next frame not detected → TRACK with miss_cnt = 1.
- FIRE:
  - Lasts exactly FIRE_CYCLES cycles, then → TRACK with both counters 0.
- Commands:
  - Issued only when at least one axis has nonzero steps and cmd_valid = 0.
  - If cmd_valid is still high, the new command is dropped; the state update still happens.
  - While cmd_valid = 1, pan_dir, pan_steps, tilt_dir and tilt_steps are held stable.
- Counters saturate and never wrap.

## Timing
- Reset values: state = SEARCH, cmd_valid = 0, all steps and dir bits = 0, laser_on = 0, locked = 0, all counters = 0.
- Reset takes effect asynchronously, including mid-FIRE: laser_on drops without waiting for a clock edge.
- State, cmd_valid and payload update on the edge that samples frame_done. They are visible the following cycle (latency 1).
- Handshake: the transfer completes on an edge where cmd_valid & cmd_ready. cmd_valid is low the next cycle.
  - cmd_ready asserted while cmd_valid = 0 has no effect.
  - A new command cannot issue in the same cycle a transfer completes. A frame_done in that cycle is treated as "pending" and its command is dropped.
- laser_on = (state == FIRE), registered. It is high for exactly FIRE_CYCLES consecutive cycles, starting the cycle after the LOCK frame_done.
- locked = (state == LOCK), registered.

## Test plan
- Reset, then frame_done with aim_detected = 1, aim = (160,120) → state = TRACK, cmd_valid = 0.
- In TRACK, aim = (200,100) → cmd_valid = 1 next cycle with pan_dir = 1, pan_steps = 10, tilt_dir = 0, tilt_steps = 5.
  - Hold cmd_ready = 0 for 3 cycles: payload stays stable.
  - A second frame_done with aim = (100,120) is dropped.
  - Raise cmd_ready: cmd_valid = 0 the next cycle.
- aim = (1023,120) → pan_steps = 63 (saturated), tilt_steps = 0, tilt_dir = 0.
- 4 centred frames → LOCK, locked = 1. 5th centred frame → laser_on high for exactly 16 cycles, then state = TRACK.
  - frame_done pulses during FIRE are ignored.
- 8 consecutive aim_detected = 0 frames in TRACK → SEARCH.
  - With only 7 misses followed by a detection, the block stays in TRACK and miss_cnt clears.
- Assert reset low at cycle 5 of FIRE → laser_on = 0 immediately, state = SEARCH, cmd_valid = 0.
